// File: rtl/fetch_stall_ctrl_pkg.sv
// rtl/fetch_stall_ctrl_pkg.sv - shared states and constants for the fetch stall controller
package fetch_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;
  localparam int          STALL_CNT_W      = 2;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with enable and priority flush
module if_id_reg #(
  parameter int           W   = 32,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc4_i,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc4_o
);

  logic [W-1:0] instr_q;
  logic [W-1:0] pc4_q;

  // Flush replaces the wrong-path instruction with a NOP even while held
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q <= NOP;
      pc4_q   <= '0;
    end else if (flush_i) begin
      instr_q <= NOP;
      pc4_q   <= '0;
    end else if (en_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - PC/IF-ID owner applying hazard stalls and branch flushes (FETCH_STALL_PERF_CNT_EN adds perf counters)
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MAX_STALL = 3,
  parameter logic [ADDR_W-1:0] NOP_WORD  = ADDR_W'(NOP_WORD_DEFAULT)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   PC_en,
  input  logic                   IF_ID_en,
  input  logic                   Ctrl_Mux,
  input  logic                   Branch_taken,
  input  logic [ADDR_W-1:0]      Branch_target,
  input  logic [ADDR_W-1:0]      Instr_in,
  output logic [ADDR_W-1:0]      PC_out,
  output logic [ADDR_W-1:0]      IF_ID_Instr,
  output logic [ADDR_W-1:0]      IF_ID_PC4,
  output logic                   ID_EX_Bubble,
  output logic [STALL_CNT_W-1:0] Stall_cnt,
  output logic                   Stall_err
`ifdef FETCH_STALL_PERF_CNT_EN
  ,
  output logic [31:0]            Perf_stall_total,
  output logic [31:0]            Perf_flush_total
`endif
);

  state_e                  state_q, state_d;
  logic                    stall;
  logic [ADDR_W-1:0]       pc_q, pc_d, pc_plus4;
  logic                    bubble_q, bubble_d;
  logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
  logic                    err_q, err_d;

  // Any single low control from the hazard unit counts as a stall
  assign stall    = !PC_en || !IF_ID_en || !Ctrl_Mux;
  assign pc_plus4 = pc_q + ADDR_W'(PC_INC);

  // Next state: a branch outranks a stall, except right after a flush
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN, STALL: begin
        if (Branch_taken)  state_d = FLUSH;
        else if (stall)    state_d = STALL;
        else               state_d = RUN;
      end
      FLUSH:   state_d = stall ? STALL : RUN;
      default: state_d = RUN;
    endcase
  end

  // Datapath follows the state being entered, so a stall holds the PC on the same edge it is seen
  always_comb begin
    pc_d     = pc_q;
    bubble_d = bubble_q;
    cnt_d    = '0;
    err_d    = err_q;
    unique case (state_d)
      RUN: begin
        pc_d     = pc_plus4;
        bubble_d = 1'b0;
      end
      STALL: begin
        bubble_d = 1'b1;
        cnt_d    = (cnt_q == STALL_CNT_MAX) ? cnt_q : cnt_q + STALL_CNT_W'(1);
        if (int'(cnt_q) == MAX_STALL) err_d = 1'b1;
      end
      FLUSH: begin
        pc_d     = {Branch_target[ADDR_W-1:2], 2'b00};
        bubble_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State, PC, bubble and watchdog registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  if_id_reg #(
    .W   (ADDR_W),
    .NOP (NOP_WORD)
  ) u_if_id_reg (
    .clk_i   (Clk),
    .rst_n_i (Rst_n),
    .en_i    (state_d == RUN),
    .flush_i (state_d == FLUSH),
    .instr_i (Instr_in),
    .pc4_i   (pc_plus4),
    .instr_o (IF_ID_Instr),
    .pc4_o   (IF_ID_PC4)
  );

  assign PC_out       = pc_q;
  assign ID_EX_Bubble = bubble_q;
  assign Stall_cnt    = cnt_q;
  assign Stall_err    = err_q;

`ifdef FETCH_STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Free-running stall and flush cycle counters, wrapping at 2^32
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (state_d == STALL) perf_stall_q <= perf_stall_q + 32'd1;
      if (state_d == FLUSH) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign Perf_stall_total = perf_stall_q;
  assign Perf_flush_total = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb/tb_fetch_stall_ctrl.sv - self-checking bench for fetch_stall_ctrl
module tb_fetch_stall_ctrl;

  localparam int          MAX_STALL = 3;
  localparam logic [31:0] NOP       = 32'h0;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        PC_en = 1'b1, IF_ID_en = 1'b1, Ctrl_Mux = 1'b1, Branch_taken = 1'b0;
  logic [31:0] Branch_target = '0;
  logic [31:0] Instr_in, PC_out, IF_ID_Instr, IF_ID_PC4;
  logic        ID_EX_Bubble, Stall_err;
  logic [1:0]  Stall_cnt;
`ifdef FETCH_STALL_PERF_CNT_EN
  logic [31:0] Perf_stall_total, Perf_flush_total;
`endif

  fetch_stall_ctrl #(
    .ADDR_W(32), .RESET_PC(32'h0), .MAX_STALL(MAX_STALL), .NOP_WORD(NOP)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .PC_en(PC_en), .IF_ID_en(IF_ID_en), .Ctrl_Mux(Ctrl_Mux),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target), .Instr_in(Instr_in),
    .PC_out(PC_out), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
    .ID_EX_Bubble(ID_EX_Bubble), .Stall_cnt(Stall_cnt), .Stall_err(Stall_err)
`ifdef FETCH_STALL_PERF_CNT_EN
    , .Perf_stall_total(Perf_stall_total), .Perf_flush_total(Perf_flush_total)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign Instr_in = imem(PC_out);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural fetch state plus length of the current stall run
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_bub, m_err, m_flush_last;
  int          m_run;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
    m_bub = 1'b1; m_err = 1'b0; m_flush_last = 1'b0; m_run = 0;
  endtask

  task automatic model_step(input bit st, input bit br, input logic [31:0] tgt);
    if (br && !m_flush_last) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_instr = NOP; m_pc4 = 32'h0; m_bub = 1'b0; m_run = 0; m_flush_last = 1'b1;
    end else if (st) begin
      m_run++;
      if (m_run > MAX_STALL) m_err = 1'b1;
      m_bub = 1'b1; m_flush_last = 1'b0;
    end else begin
      m_instr = imem(m_pc);
      m_pc = m_pc + 32'd4;
      m_pc4 = m_pc;
      m_bub = 1'b0; m_run = 0; m_flush_last = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pc"},     PC_out,       m_pc);
    chk({tag, " instr"},  IF_ID_Instr,  m_instr);
    chk({tag, " pc4"},    IF_ID_PC4,    m_pc4);
    chk({tag, " bubble"}, ID_EX_Bubble, 32'(m_bub));
    chk({tag, " cnt"},    Stall_cnt,    32'((m_run > 3) ? 3 : m_run));
    chk({tag, " err"},    Stall_err,    32'(m_err));
  endtask

  task automatic drive(input bit pe, input bit ie, input bit cm, input bit br, input logic [31:0] tgt);
    PC_en = pe; IF_ID_en = ie; Ctrl_Mux = cm; Branch_taken = br; Branch_target = tgt;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step(!(PC_en && IF_ID_en && Ctrl_Mux), Branch_taken, Branch_target);
    @(negedge Clk);
  endtask

  typedef struct {
    bit          pe, ie, cm, br;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_pc4, e_instr;
    bit          e_bub;
    logic [1:0]  e_cnt;
    bit          e_err;
  } vec_t;

  function automatic vec_t mk(input bit pe, input bit ie, input bit cm, input bit br,
                              input logic [31:0] tgt, input logic [31:0] e_pc,
                              input logic [31:0] e_pc4, input logic [31:0] e_instr,
                              input bit e_bub, input logic [1:0] e_cnt, input bit e_err);
    vec_t v;
    v.pe = pe; v.ie = ie; v.cm = cm; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr;
    v.e_bub = e_bub; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    tbl[0]  = mk(1,1,1,0, 32'h0,   32'h4,   32'h4,   imem(32'h0),  0, 0, 0);
    tbl[1]  = mk(1,1,1,0, 32'h0,   32'h8,   32'h8,   imem(32'h4),  0, 0, 0);
    tbl[2]  = mk(0,0,0,0, 32'h0,   32'h8,   32'h8,   imem(32'h4),  1, 1, 0);
    tbl[3]  = mk(0,0,0,0, 32'h0,   32'h8,   32'h8,   imem(32'h4),  1, 2, 0);
    tbl[4]  = mk(1,1,1,0, 32'h0,   32'hC,   32'hC,   imem(32'h8),  0, 0, 0);
    tbl[5]  = mk(1,1,1,0, 32'h0,   32'h10,  32'h10,  imem(32'hC),  0, 0, 0);
    tbl[6]  = mk(1,1,1,1, 32'h40,  32'h40,  32'h0,   NOP,          0, 0, 0);
    tbl[7]  = mk(1,1,1,0, 32'h0,   32'h44,  32'h44,  imem(32'h40), 0, 0, 0);
    tbl[8]  = mk(0,1,1,1, 32'h83,  32'h80,  32'h0,   NOP,          0, 0, 0);
    tbl[9]  = mk(1,1,1,1, 32'h200, 32'h84,  32'h84,  imem(32'h80), 0, 0, 0);
    tbl[10] = mk(1,1,0,0, 32'h0,   32'h84,  32'h84,  imem(32'h80), 1, 1, 0);
    tbl[11] = mk(1,0,1,0, 32'h0,   32'h84,  32'h84,  imem(32'h80), 1, 2, 0);
    tbl[12] = mk(0,0,0,0, 32'h0,   32'h84,  32'h84,  imem(32'h80), 1, 3, 0);
    tbl[13] = mk(0,0,0,0, 32'h0,   32'h84,  32'h84,  imem(32'h80), 1, 3, 1);
    tbl[14] = mk(0,0,0,0, 32'h0,   32'h84,  32'h84,  imem(32'h80), 1, 3, 1);
    tbl[15] = mk(1,1,1,0, 32'h0,   32'h88,  32'h88,  imem(32'h84), 0, 0, 1);
    tbl[16] = mk(1,1,1,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, NOP, 0, 0, 1);
    tbl[17] = mk(0,0,0,1, 32'h100, 32'hFFFF_FFFC, 32'h0, NOP,      1, 1, 1);
    tbl[18] = mk(1,1,1,0, 32'h0,   32'h0,   32'h0,   imem(32'hFFFF_FFFC), 0, 0, 1);

    // Reset state
    drive(1, 1, 1, 0, 32'h0);
    repeat (2) @(negedge Clk);
    chk("reset pc",     PC_out,       32'h0);
    chk("reset instr",  IF_ID_Instr,  NOP);
    chk("reset pc4",    IF_ID_PC4,    32'h0);
    chk("reset bubble", ID_EX_Bubble, 32'h1);
    chk("reset cnt",    Stall_cnt,    32'h0);
    chk("reset err",    Stall_err,    32'h0);
    Rst_n = 1'b1;
    model_reset();

    // Directed vectors
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].pe, tbl[i].ie, tbl[i].cm, tbl[i].br, tbl[i].tgt);
      tick();
      chk($sformatf("row%0d pc", i),     PC_out,       tbl[i].e_pc);
      chk($sformatf("row%0d pc4", i),    IF_ID_PC4,    tbl[i].e_pc4);
      chk($sformatf("row%0d instr", i),  IF_ID_Instr,  tbl[i].e_instr);
      chk($sformatf("row%0d bubble", i), ID_EX_Bubble, 32'(tbl[i].e_bub));
      chk($sformatf("row%0d cnt", i),    Stall_cnt,    32'(tbl[i].e_cnt));
      chk($sformatf("row%0d err", i),    Stall_err,    32'(tbl[i].e_err));
    end

    // Asynchronous reset pulse in the middle of a stall
    drive(0, 0, 0, 0, 32'h0);
    tick();
    tick();
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async pc",     PC_out,       32'h0);
    chk("async instr",  IF_ID_Instr,  NOP);
    chk("async pc4",    IF_ID_PC4,    32'h0);
    chk("async bubble", ID_EX_Bubble, 32'h1);
    chk("async cnt",    Stall_cnt,    32'h0);
    chk("async err",    Stall_err,    32'h0);
    drive(1, 1, 1, 0, 32'h0);
    #1;
    Rst_n = 1'b1;
    model_reset();
    tick();
    chk("release pc", PC_out, 32'h4);
    check_model("release");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit          st, br;
      logic [2:0]  drop;
      logic [31:0] tgt;
      st   = ($urandom_range(0, 99) < 30);
      drop = st ? 3'($urandom_range(1, 7)) : 3'd0;
      br   = ($urandom_range(0, 99) < 15);
      tgt  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(!drop[0], !drop[1], !drop[2], br, tgt);
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Consumer end of the hazard-unit stall interface. Owns the PC register and the IF/ID pipeline register.
- Applies the PC_en, IF_ID_en and Ctrl_Mux stall controls, and flushes IF/ID on a taken branch.
- Runs a watchdog that flags stalls lasting longer than any legal hazard window.
- Sits between instruction memory and the ID stage.

Parameters:
- ADDR_W, 32, width of PC and instruction word
- RESET_PC, 0, PC value loaded on reset
- MAX_STALL, 3, longest legal run of consecutive stall cycles before Stall_err is raised
- NOP_WORD, 0, instruction injected into IF/ID on flush

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- PC_en  in  1  from hazard unit; 0 holds the PC
- IF_ID_en  in  1  from hazard unit; 0 holds IF/ID
- Ctrl_Mux  in  1  from hazard unit; 0 requests a bubble into ID/EX
- Branch_taken  in  1  branch resolved taken (ID stage)
- Branch_target  in  ADDR_W  redirect address
- Instr_in  in  ADDR_W  instruction memory read data at PC_out
- PC_out  out  ADDR_W  current fetch address
- IF_ID_Instr  out  ADDR_W  registered instruction
- IF_ID_PC4  out  ADDR_W  registered PC+4
- ID_EX_Bubble  out  1  registered; 1 forces ID/EX control bits to zero
- Stall_cnt  out  2  consecutive stall cycles, saturating at 3
- Stall_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, Rst_n=0) sets:
  - PC_out=RESET_PC, IF_ID_Instr=NOP_WORD, IF_ID_PC4=0
  - ID_EX_Bubble=1, Stall_cnt=0, Stall_err=0, state=RUN
  - Deassertion takes effect at the next Clk edge.
- Stall condition: stall = (!PC_en || !IF_ID_en || !Ctrl_Mux). The hazard unit drives all three together; any single 0 is treated as a stall.
- State RUN:
  - PC_out <= PC_out+4.
  - IF_ID <= {Instr_in, PC_out+4}.
  - ID_EX_Bubble <= 0.
  - stall goes to STALL. Branch_taken goes to FLUSH.
- State STALL:
  - PC_out, IF_ID_Instr and IF_ID_PC4 hold.
  - ID_EX_Bubble <= 1.
  - Stall_cnt increments, saturating at 3.
  - Returns to RUN when stall drops.
- State FLUSH (exactly one cycle):
  - PC_out <= Branch_target.
  - IF_ID_Instr <= NOP_WORD, IF_ID_PC4 <= 0.
  - ID_EX_Bubble <= 0.
  - Then goes to RUN, or to STALL if stall is asserted.
- Priority: Branch_taken beats stall. A branch in the same cycle as a stall flushes, since the stalled instruction is on the wrong path.
- Branch_taken while in FLUSH is ignored.
- Stall_cnt clears to 0 on any cycle without stall.
- Stall_err is set when Stall_cnt == MAX_STALL and stall is still asserted. It stays set until reset.
- PC wraps modulo 2^ADDR_W; 0xFFFFFFFC+4 gives 0.
- Branch_target[1:0] is ignored and forced to 00.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: the instruction at PC_out appears on IF_ID_Instr one cycle later when not stalled.

Optional Feature:
- Macro: FETCH_STALL_PERF_CNT_EN
- Defined:
  - Adds output Perf_stall_total (32 bits) and output Perf_flush_total (32 bits).
  - Each increments once per STALL or FLUSH cycle respectively, wraps at 2^32, and resets to 0.
- Undefined: the ports and counters are absent, with no logic cost.

Decomposition:
- Shared package holds:
  - state enum (RUN=2'd0, STALL=2'd1, FLUSH=2'd2)
  - NOP_WORD default
  - PC increment constant 4
  - Stall_cnt width
- Natural sub-module: if_id_reg.
  - Enable/flush pipeline register for Instr and PC4.
  - Flush has priority over hold.

Test Plan:
1. Reset, then 4 cycles with PC_en=IF_ID_en=Ctrl_Mux=1, RESET_PC=0:
   - PC_out goes 0,4,8,12.
   - IF_ID_PC4 lags by one cycle.
   - ID_EX_Bubble goes 1 then 0.
2. Drive all stall inputs 0 for 2 cycles at PC=8:
   - PC_out=8 and IF_ID hold for both cycles.
   - ID_EX_Bubble=1 and Stall_cnt goes 1,2.
   - Resume gives PC=12 and Stall_cnt=0.
3. Branch_taken=1 with Branch_target=0x40 at PC=16:
   - Next cycle PC_out=0x40, IF_ID_Instr=NOP_WORD.
   - Following cycle PC_out=0x44.
4. Branch_taken and stall in the same cycle: flush wins and PC_out=Branch_target.
5. Hold stall for 5 cycles with MAX_STALL=3:
   - Stall_err rises on the 4th stall cycle and remains 1 after the stall ends.
6. Pulse Rst_n low mid-STALL, asynchronously between edges:
   - Outputs immediately return to reset values.
   - First edge after release fetches RESET_PC+4.
